// File: rtl/math_sched_if.sv
// Request/grant/result bundle between two requesters and the shared math scheduler.
interface math_sched_if;
  logic        req0;
  logic [1:0]  op0;
  logic [15:0] a0;
  logic [15:0] b0;
  logic        req1;
  logic [1:0]  op1;
  logic [15:0] a1;
  logic [15:0] b1;
  logic        gnt0;
  logic        gnt1;
  logic        done;
  logic        done_id;
  logic [15:0] result;
  logic        div_zero;
  logic        busy;

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    input  gnt0, gnt1, done, done_id, result, div_zero, busy
  );

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    output gnt0, gnt1, done, done_id, result, div_zero, busy
  );
endinterface

// File: rtl/math_sched.sv
// Two-requester round-robin scheduler for a shared 16-bit add/sub/mul/div unit.
// Multiply and divide are iterative, one bit per cycle.
module math_sched (
  input  logic         clk,
  input  logic         rst,
  math_sched_if.slave  bus
);
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] ITER_LAST = CW'(DW - 1);
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e          state_q, state_d;
  logic            id_q, id_d;
  logic [1:0]      op_q, op_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            gnt0_q, gnt0_d;
  logic            gnt1_q, gnt1_d;
  logic            done_q, done_d;
  logic            done_id_q, done_id_d;
  logic [DW-1:0]   result_q, result_d;
  logic            div_zero_q, div_zero_d;
  logic            busy_q, busy_d;

  logic            grant_id;
  logic [DW:0]     rem_sh;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done_d     = 1'b0;
    done_id_d  = done_id_q;
    result_d   = result_q;
    div_zero_d = 1'b0;

    grant_id = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    rem_sh   = {acc_q, a_q[DW-1]};

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          id_d    = grant_id;
          op_d    = grant_id ? bus.op1 : bus.op0;
          a_d     = grant_id ? bus.a1  : bus.a0;
          b_d     = grant_id ? bus.b1  : bus.b0;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = EXEC;
        end
      end

      EXEC: begin
        gnt0_d = (cnt_q == '0) && !id_q;
        gnt1_d = (cnt_q == '0) &&  id_q;
        cnt_d  = cnt_q + CW'(1);
        case (op_q)
          OP_ADD: begin
            acc_d   = DW'(a_q + b_q);
            state_d = DONE;
          end
          OP_SUB: begin
            acc_d   = DW'(a_q - b_q);
            state_d = DONE;
          end
          OP_MUL: begin
            // a_q is the shifted multiplicand, b_q the shifted multiplier
            if (b_q[0]) acc_d = DW'(acc_q + a_q);
            a_d = {a_q[DW-2:0], 1'b0};
            b_d = {1'b0, b_q[DW-1:1]};
            if (cnt_q == ITER_LAST) state_d = DONE;
          end
          default: begin
            // Restoring divide: acc_q is the partial remainder, a_q shifts quotient bits in
            if (rem_sh >= {1'b0, b_q}) begin
              acc_d = DW'(rem_sh - {1'b0, b_q});
              a_d   = {a_q[DW-2:0], 1'b1};
            end else begin
              acc_d = DW'(rem_sh);
              a_d   = {a_q[DW-2:0], 1'b0};
            end
            if (cnt_q == ITER_LAST) state_d = DONE;
          end
        endcase
      end

      DONE: begin
        done_d     = 1'b1;
        done_id_d  = id_q;
        last_d     = id_q;
        div_zero_d = (op_q == OP_DIV) && (b_q == '0);
        if (op_q == OP_DIV) result_d = (b_q == '0) ? '1 : a_q;
        else                result_d = acc_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done_q     <= done_d;
      done_id_q  <= done_id_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done     = done_q;
  assign bus.done_id  = done_id_q;
  assign bus.result   = result_q;
  assign bus.div_zero = div_zero_q;
  assign bus.busy     = busy_q;
endmodule

// File: doc/math_sched.md
MATH_SCHED -- requirements
Module: math_sched

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: req0  input  1  requester 0 operation request, level, held until gnt0.
REQ-004 SHALL have port: op0  input  2  requester 0 opcode: 0 add, 1 sub, 2 mul, 3 div.
REQ-005 SHALL have ports: a0, b0  input  16 each  requester 0 operands, unsigned.
REQ-006 SHALL have ports: req1, op1, a1, b1  input  1/2/16/16  requester 1, same meaning as requester 0.
REQ-007 SHALL have ports: gnt0, gnt1  output  1 each  one-cycle pulse; operands of that requester captured.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have port: done_id  output  1  requester that owns the current result.
REQ-010 SHALL have port: result  output  16  operation result, held until next done.
REQ-011 SHALL have port: div_zero  output  1  qualifies done: divide with b == 0.
REQ-012 SHALL have port: busy  output  1  high in every state other than IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; gnt0/gnt1/done/div_zero/busy registered.
REQ-014 IDLE, no request: SHALL stay in IDLE.
REQ-015 IDLE, one request high at an edge: SHALL capture that requester's op/a/b, pulse its gnt the next cycle, go to EXEC, clear iteration counter.
REQ-016 IDLE, both requests high: SHALL grant round-robin, the requester not served last; last-served pointer resets to 1, so req0 wins the first tie.
REQ-017 Requests arriving outside IDLE SHALL be ignored (no queueing); req dropped before its gnt SHALL be treated as withdrawn.
REQ-018 EXEC add/sub: SHALL take 1 cycle; result = (a +/- b) mod 2^16; wrap-around, no carry/borrow output.
REQ-019 EXEC mul: SHALL run 16 shift-add iterations, one multiplier bit per cycle, LSB first; result = low 16 bits of a*b.
REQ-020 EXEC div: SHALL run 16 restoring-division iterations, one quotient bit per cycle, MSB first; result = floor(a/b), remainder discarded.
REQ-021 div with b == 0: SHALL still take 16 cycles; result = 16'hFFFF, div_zero = 1 with done.
REQ-022 Latency: done SHALL assert exactly N+1 edges after the capturing edge, N = 1 (add/sub) or 16 (mul/div); gnt precedes done by N cycles.
REQ-023 DONE: SHALL pulse done for one cycle, drive done_id, update result, update last-served pointer, return to IDLE.
REQ-024 Back-to-back: the earliest next grant SHALL capture on the edge after DONE, so requests are separated by at least one IDLE cycle.
REQ-025 gnt0 and gnt1 SHALL never be high together; at most one gnt per operation.
REQ-026 Operand inputs SHALL be ignored after capture; changing a/b/op during EXEC SHALL not affect the result.

Reset
REQ-027 rst high at an edge SHALL force IDLE; gnt0/gnt1/done/div_zero/busy/done_id = 0; result = 16'h0000; pointer = 1; counter = 0.
REQ-028 rst during EXEC or DONE SHALL abort the operation; no done pulse for it; rst has priority over all other events in the same cycle.
REQ-029 First grant after rst release SHALL not occur before the first edge with rst low.

Verification
REQ-030 req0, op0=0, a0=16'hFFFF, b0=16'h0002 -> gnt0, done 2 edges after capture, result=16'h0001, done_id=0.
REQ-031 req1, op1=2, a1=300, b1=300 -> done 17 edges after capture, result=16'h5F90 (90000 mod 65536 = 24464), done_id=1.
REQ-032 req0, op0=3, a0=1000, b0=7 -> result=142, div_zero=0; then a0=5, b0=0 -> result=16'hFFFF, div_zero=1.
REQ-033 req0 and req1 both held high, op=1, a=3, b=5 -> grants alternate 0,1,0,1; each result=16'hFFFE; never both gnt high.
REQ-034 rst pulsed 8 cycles into a mul -> no done; all outputs 0; a new add 2+2 then completes with result=4.
REQ-035 a0/b0 changed on every cycle during a div of 100/10 -> result=10.
